instr_register_sequencer: RTL and testbench
===========================================

# instr_register_sequencer

Front-end controller for the 32-entry instruction register. Two requesters submit (opcode, operand_a, operand_b) instructions through valid/ready handshakes. A round-robin arbiter picks one per cycle and drives the register's write port at a circular write pointer. The read port is drained in FIFO order to one consumer through a valid/ready response handshake, with a run/drain state machine.

## Interface
- DEPTH, 32: register entries; must equal 2**$bits(address_t)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  pulse; IDLE -> RUN
- drain  in  1  pulse; RUN -> DRAIN
- busy  out  1  state != IDLE
- req_valid  in  [1:0]  per-requester instruction valid
- req_ready  out  [1:0]  per-requester accept
- req_opcode  in  opcode_t x2  per-requester opcode
- req_operand_a / req_operand_b  in  operand_t x2  per-requester operands
- load_en  out  1  to register write enable
- write_pointer / read_pointer  out  address_t  to register pointers
- opcode, operand_a, operand_b  out  opcode_t / operand_t  to register write data
- instruction_word  in  instruction_t  from register (combinational read)
- rsp_valid  out  1  head entry available
- rsp_ready  in  1  consumer accepts head
- rsp_instr  out  instruction_t  = instruction_word while rsp_valid, else '0
- rsp_src  out  1  requester id of head entry
- count  out  6  occupied entries, 0..32

## Operation
- States: IDLE, RUN, DRAIN. IDLE: req_ready=0, responses still served. start in IDLE -> RUN (start ignored elsewhere). drain in RUN -> DRAIN. DRAIN: req_ready=0; when count==0 -> IDLE. drain and start in same cycle: drain wins only in RUN.
- Accept: in RUN with count<32, arbiter grants one valid requester; req_ready[g]=1 only for granted g. Handshake = req_valid[g] & req_ready[g].
- Arbitration: round-robin; last-granted pointer lg (reset 1, so requester 0 wins first tie). Both valid -> grant !lg. One valid -> grant it. lg updates only on handshake.
- Write: load_en = handshake, combinational; write_pointer = wr_ptr; opcode/operands muxed from granted requester. Register captures on the same edge; wr_ptr += 1 (mod 32); src[wr_ptr] <= g.
- Read: read_pointer = rd_ptr; rsp_valid = (count!=0); pop = rsp_valid & rsp_ready; rd_ptr += 1 (mod 32) on pop.
- count: +1 on handshake only, -1 on pop only, unchanged on both.
- Full (count==32): req_ready=0 even if pop same cycle; accept resumes next cycle.
- Empty: rsp_valid=0, rsp_ready ignored.
- Wrap: pointers wrap 31->0 silently; full/empty from count, never from pointer compare.
- Reset mid-operation: pointers, count, state cleared asynchronously. Register contents are not cleared by this block and are unobservable because rsp_valid is gated by count.

## Timing
- Reset values: req_ready 0, load_en 0, write/read_pointer 0, opcode/operands '0, rsp_valid 0, rsp_instr '0, rsp_src 0, count 0, busy 0, state IDLE.
- Request-to-response latency: handshake at edge N, rsp_valid at N+1 if queue was empty.
- Throughput: 1 accept and 1 pop per cycle.
- start at edge N: req_ready may assert after N. drain at edge N: req_ready=0 after N.
- req_ready depends combinationally on req_valid. Requesters must not make req_valid depend on req_ready.

## Configuration
- INSTR_SEQ_STATS_EN defined: adds outputs acc_cnt0, acc_cnt1 (16 bits each, saturating at 16'hFFFF). Each counts handshakes for its requester and is cleared by reset.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- instr_register_pkg: existing opcode_t, operand_t, address_t, instruction_t. Add seq_state_t enum {IDLE, RUN, DRAIN} and constant DEPTH=32.
- Sub-module rr_arbiter2: inputs req[1:0], advance. Outputs grant[1:0], grant_id. Holds the lg pointer.
- src[0:31] side array kept in the sequencer.

## Test plan
- Reset then start; req0 ADD a=5,b=3 -> load_en 1 for one cycle, write_pointer 0. Next cycle: rsp_valid 1, rsp_instr.opc ADD with result 8, rsp_src 0, count 1.
- Both requesters valid continuously for 4 cycles: req0 PASSA a=1, req1 PASSB b=2 -> grants 0,1,0,1; rsp_src sequence 0,1,0,1.
- rsp_ready=0, req0 pushes 33 times -> count 32, req_ready 0 on 33rd. One pop -> accept next cycle at write_pointer 0 (wrap).
- Push and pop every cycle for 40 cycles at count 1 -> count stays 1. Pointers wrap 31->0 with FIFO order preserved.
- 5 entries queued, drain pulse -> req_ready 0 immediately. 5 pops, then IDLE, busy 0. start -> RUN.
- reset asserted at count 7 mid-drain -> count 0, rsp_valid 0, pointers 0, state IDLE asynchronously.

Source files
------------

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its front-end sequencer.
// Optional feature macro used by the sequencer: INSTR_SEQ_STATS_EN.
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO,
        PASSA,
        PASSB,
        ADD,
        SUB,
        MULT,
        DIV,
        MOD
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic signed [63:0] result_t;
    typedef logic [4:0]         address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        result_t  result;
    } instruction_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } seq_state_t;

    localparam int DEPTH   = 32;
    localparam int COUNT_W = $clog2(DEPTH) + 1;

    // Saturating increment for the per-requester accept statistics.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/instr_register_sequencer_if.sv
// Requester and response handshake bundle of the instruction register sequencer.
interface instr_register_sequencer_if;
    import instr_register_pkg::*;

    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    opcode_t  [1:0]     req_opcode;
    operand_t [1:0]     req_operand_a;
    operand_t [1:0]     req_operand_b;

    logic               rsp_valid;
    logic               rsp_ready;
    instruction_t       rsp_instr;
    logic               rsp_src;

    modport slave (
        input  req_valid, req_opcode, req_operand_a, req_operand_b, rsp_ready,
        output req_ready, rsp_valid, rsp_instr, rsp_src
    );

    modport master (
        output req_valid, req_opcode, req_operand_a, req_operand_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_instr, rsp_src
    );

endinterface

// File: rtl/instr_register_sequencer_rr_arbiter2.sv
// Two-way round-robin arbiter; the last-granted pointer moves only when a grant is taken.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       grant_id
);

    logic lg;

    always_comb begin
        grant_id = 1'b0;
        grant    = 2'b00;
        case (req)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~lg;
            default: grant_id = 1'b0;
        endcase
        if (|req) grant[grant_id] = 1'b1;
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        lg <= 1'b1;
        else if (advance) lg <= grant_id;
    end

endmodule

// File: rtl/instr_register_sequencer.sv
// Front-end sequencer for the 32-entry instruction register: arbitrated writes, FIFO-order reads.
// Optional statistics outputs acc_cnt0/acc_cnt1 are built when INSTR_SEQ_STATS_EN is defined.
module instr_register_sequencer
    import instr_register_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   drain,
    output logic                   busy,
    instr_register_sequencer_if.slave bus,
    output logic                   load_en,
    output address_t               write_pointer,
    output address_t               read_pointer,
    output opcode_t                opcode,
    output operand_t               operand_a,
    output operand_t               operand_b,
    input  instruction_t           instruction_word,
`ifdef INSTR_SEQ_STATS_EN
    output logic [15:0]            acc_cnt0,
    output logic [15:0]            acc_cnt1,
`endif
    output logic [COUNT_W-1:0]     count
);

    seq_state_t         state;
    seq_state_t         state_nx;
    address_t           wr_ptr;
    address_t           rd_ptr;
    logic [COUNT_W-1:0] cnt;
    logic               src [DEPTH];

    logic [1:0]         grant;
    logic               gid;
    logic [1:0]         ready;
    logic               full;
    logic               can_accept;
    logic               handshake;
    logic               rsp_valid;
    logic               pop;

    assign full = (cnt == COUNT_W'(DEPTH));

    rr_arbiter2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      (bus.req_valid),
        .advance  (handshake),
        .grant    (grant),
        .grant_id (gid)
    );

    always_comb begin
        state_nx   = state;
        busy       = 1'b1;
        can_accept = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = RUN;
            end
            RUN: begin
                can_accept = !full;
                if (drain) state_nx = DRAIN;
            end
            DRAIN: begin
                if (cnt == '0) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign ready         = can_accept ? grant : 2'b00;
    assign bus.req_ready = ready;
    assign handshake     = |(bus.req_valid & ready);

    assign load_en       = handshake;
    assign write_pointer = wr_ptr;
    assign read_pointer  = rd_ptr;
    assign opcode        = handshake ? bus.req_opcode[gid]    : ZERO;
    assign operand_a     = handshake ? bus.req_operand_a[gid] : '0;
    assign operand_b     = handshake ? bus.req_operand_b[gid] : '0;

    // Register contents are never cleared, so everything read back is gated by occupancy.
    assign rsp_valid     = (cnt != '0);
    assign pop           = rsp_valid & bus.rsp_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_instr = rsp_valid ? instruction_word : '0;
    assign bus.rsp_src   = rsp_valid & src[rd_ptr];
    assign count         = cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            state <= state_nx;
            if (handshake) wr_ptr <= wr_ptr + address_t'(1);
            if (pop)       rd_ptr <= rd_ptr + address_t'(1);
            case ({handshake, pop})
                2'b10:   cnt <= cnt + COUNT_W'(1);
                2'b01:   cnt <= cnt - COUNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (handshake) src[wr_ptr] <= gid;
    end

`ifdef INSTR_SEQ_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_cnt0 <= '0;
            acc_cnt1 <= '0;
        end else if (handshake) begin
            if (gid == 1'b0) acc_cnt0 <= sat_inc16(acc_cnt0);
            else             acc_cnt1 <= sat_inc16(acc_cnt1);
        end
    end
`endif

endmodule

// File: tb/tb_instr_register_sequencer.sv
// Directed self-checking bench for instr_register_sequencer with a behavioural instruction register.
module tb_instr_register_sequencer;
    import instr_register_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         drain;
    logic         busy;
    logic         load_en;
    address_t     write_pointer;
    address_t     read_pointer;
    opcode_t      opcode;
    operand_t     operand_a;
    operand_t     operand_b;
    instruction_t instruction_word;
    logic [5:0]   count;
`ifdef INSTR_SEQ_STATS_EN
    logic [15:0]  acc_cnt0;
    logic [15:0]  acc_cnt1;
`endif

    int checks = 0;
    int errors = 0;

    instr_register_sequencer_if bus ();

    instr_register_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .drain            (drain),
        .busy             (busy),
        .bus              (bus),
        .load_en          (load_en),
        .write_pointer    (write_pointer),
        .read_pointer     (read_pointer),
        .opcode           (opcode),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .instruction_word (instruction_word),
`ifdef INSTR_SEQ_STATS_EN
        .acc_cnt0         (acc_cnt0),
        .acc_cnt1         (acc_cnt1),
`endif
        .count            (count)
    );

    always #5 clk = ~clk;

    function automatic result_t calc(input opcode_t op, input operand_t a, input operand_t b);
        case (op)
            PASSA:   return result_t'(a);
            PASSB:   return result_t'(b);
            ADD:     return result_t'(a) + result_t'(b);
            SUB:     return result_t'(a) - result_t'(b);
            MULT:    return result_t'(a) * result_t'(b);
            DIV:     return (b == 0) ? '0 : result_t'(a / b);
            MOD:     return (b == 0) ? '0 : result_t'(a % b);
            default: return '0;
        endcase
    endfunction

    // Behavioural instruction register: captures on load_en, combinational read.
    instruction_t regf [32];
    always @(posedge clk) begin
        if (load_en) begin
            regf[write_pointer] <= '{opc: opcode, op_a: operand_a, op_b: operand_b,
                                     result: calc(opcode, operand_a, operand_b)};
        end
    end
    assign instruction_word = regf[read_pointer];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0] v;
        opcode_t    op0;
        operand_t   a0;
        operand_t   b0;
        opcode_t    op1;
        operand_t   a1;
        operand_t   b1;
        logic       rr;
        logic [1:0] e_ready;
        logic       e_load;
        logic [4:0] e_wp;
        logic [5:0] e_cnt;
        logic       e_rv;
        logic       e_src;
        opcode_t    e_opc;
        result_t    e_res;
    } vec_t;

    function automatic vec_t row(input logic [1:0] v, input opcode_t op0, input int a0, input int b0,
                                 input opcode_t op1, input int a1, input int b1, input logic rr,
                                 input logic [1:0] e_ready, input logic e_load, input int e_wp,
                                 input int e_cnt, input logic e_rv, input logic e_src,
                                 input opcode_t e_opc, input longint e_res);
        vec_t r;
        r.v = v; r.op0 = op0; r.a0 = a0; r.b0 = b0;
        r.op1 = op1; r.a1 = a1; r.b1 = b1; r.rr = rr;
        r.e_ready = e_ready; r.e_load = e_load; r.e_wp = 5'(e_wp); r.e_cnt = 6'(e_cnt);
        r.e_rv = e_rv; r.e_src = e_src; r.e_opc = e_opc; r.e_res = e_res;
        return r;
    endfunction

    task automatic drive(input logic [1:0] v, input opcode_t op0, input int a0, input int b0,
                         input opcode_t op1, input int a1, input int b1, input logic rr);
        bus.req_valid        = v;
        bus.req_opcode[0]    = op0;
        bus.req_operand_a[0] = a0;
        bus.req_operand_b[0] = b0;
        bus.req_opcode[1]    = op1;
        bus.req_operand_a[1] = a1;
        bus.req_operand_b[1] = b1;
        bus.rsp_ready        = rr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        drain = 1'b0;
        drive(2'b00, ZERO, 0, 0, ZERO, 0, 0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    vec_t tbl [13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        drain = 1'b0;
        drive(2'b00, ZERO, 0, 0, ZERO, 0, 0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state, IDLE with a request present.
        drive(2'b01, ADD, 1, 1, ZERO, 0, 0, 1'b1);
        #1;
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_load", 64'(load_en), 64'd0);
        chk("rst_wp", 64'(write_pointer), 64'd0);
        chk("rst_rp", 64'(read_pointer), 64'd0);
        chk("rst_opcode", 64'(opcode), 64'd0);
        chk("rst_opa", 64'(operand_a), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_instr", 64'(bus.rsp_instr[63:0]), 64'd0);
        chk("rst_rsp_src", 64'(bus.rsp_src), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        drive(2'b00, ZERO, 0, 0, ZERO, 0, 0, 1'b0);
        pulse_start();
        #1;
        chk("start_busy", 64'(busy), 64'd1);

        //          v      op0    a0 b0 op1    a1 b1 rr  rdy    ld  wp cnt rv  src  opc    res
        tbl[0]  = row(2'b01, ADD,   5, 3, ZERO,  0, 0, 0, 2'b01, 1, 0, 0, 0, 0, ZERO,  0);
        tbl[1]  = row(2'b00, ZERO,  0, 0, ZERO,  0, 0, 0, 2'b00, 0, 1, 1, 1, 0, ADD,   8);
        tbl[2]  = row(2'b00, ZERO,  0, 0, ZERO,  0, 0, 1, 2'b00, 0, 1, 1, 1, 0, ADD,   8);
        tbl[3]  = row(2'b10, ZERO,  0, 0, PASSB, 0, 2, 1, 2'b10, 1, 1, 0, 0, 0, ZERO,  0);
        tbl[4]  = row(2'b11, PASSA, 1, 0, PASSB, 0, 2, 1, 2'b01, 1, 2, 1, 1, 1, PASSB, 2);
        tbl[5]  = row(2'b11, PASSA, 1, 0, PASSB, 0, 2, 1, 2'b10, 1, 3, 1, 1, 0, PASSA, 1);
        tbl[6]  = row(2'b11, PASSA, 1, 0, PASSB, 0, 2, 1, 2'b01, 1, 4, 1, 1, 1, PASSB, 2);
        tbl[7]  = row(2'b11, PASSA, 1, 0, PASSB, 0, 2, 1, 2'b10, 1, 5, 1, 1, 0, PASSA, 1);
        tbl[8]  = row(2'b00, ZERO,  0, 0, ZERO,  0, 0, 1, 2'b00, 0, 6, 1, 1, 1, PASSB, 2);
        tbl[9]  = row(2'b00, ZERO,  0, 0, ZERO,  0, 0, 1, 2'b00, 0, 6, 0, 0, 0, ZERO,  0);
        tbl[10] = row(2'b01, SUB,   3, 10, ZERO, 0, 0, 0, 2'b01, 1, 6, 0, 0, 0, ZERO,  0);
        tbl[11] = row(2'b00, ZERO,  0, 0, ZERO,  0, 0, 0, 2'b00, 0, 7, 1, 1, 0, SUB,  -7);
        tbl[12] = row(2'b00, ZERO,  0, 0, ZERO,  0, 0, 1, 2'b00, 0, 7, 1, 1, 0, SUB,  -7);

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].v, tbl[i].op0, tbl[i].a0, tbl[i].b0,
                  tbl[i].op1, tbl[i].a1, tbl[i].b1, tbl[i].rr);
            #1;
            chk($sformatf("row%0d_ready", i), 64'(bus.req_ready), 64'(tbl[i].e_ready));
            chk($sformatf("row%0d_load", i), 64'(load_en), 64'(tbl[i].e_load));
            chk($sformatf("row%0d_wp", i), 64'(write_pointer), 64'(tbl[i].e_wp));
            chk($sformatf("row%0d_count", i), 64'(count), 64'(tbl[i].e_cnt));
            chk($sformatf("row%0d_rsp_valid", i), 64'(bus.rsp_valid), 64'(tbl[i].e_rv));
            chk($sformatf("row%0d_rsp_src", i), 64'(bus.rsp_src), 64'(tbl[i].e_src));
            if (tbl[i].e_rv) begin
                chk($sformatf("row%0d_opc", i), 64'(bus.rsp_instr.opc), 64'(tbl[i].e_opc));
                chk($sformatf("row%0d_result", i), bus.rsp_instr.result, tbl[i].e_res);
            end else begin
                chk($sformatf("row%0d_instr_zero", i), bus.rsp_instr[63:0], 64'd0);
            end
            @(negedge clk);
        end
`ifdef INSTR_SEQ_STATS_EN
        chk("stats_acc0", 64'(acc_cnt0), 64'd4);
        chk("stats_acc1", 64'(acc_cnt1), 64'd3);
`endif

        // Fill to 32, refuse the 33rd, then refuse again during a pop and resume after it.
        do_reset();
        pulse_start();
        for (int i = 0; i < 32; i++) begin
            drive(2'b01, PASSA, i, 0, ZERO, 0, 0, 1'b0);
            #1;
            chk($sformatf("fill%0d_ready", i), 64'(bus.req_ready), 64'd1);
            chk($sformatf("fill%0d_wp", i), 64'(write_pointer), 64'(i));
            chk($sformatf("fill%0d_count", i), 64'(count), 64'(i));
            @(negedge clk);
        end
        drive(2'b01, PASSA, 32, 0, ZERO, 0, 0, 1'b0);
        #1;
        chk("full_count", 64'(count), 64'd32);
        chk("full_ready", 64'(bus.req_ready), 64'd0);
        chk("full_load", 64'(load_en), 64'd0);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        #1;
        chk("full_pop_ready", 64'(bus.req_ready), 64'd0);
        chk("full_head", 64'(bus.rsp_instr.op_a), 64'd0);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        #1;
        chk("resume_count", 64'(count), 64'd31);
        chk("resume_ready", 64'(bus.req_ready), 64'd1);
        chk("resume_wp_wrap", 64'(write_pointer), 64'd0);
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1;
        chk("refull_count", 64'(count), 64'd32);
        chk("refull_head", 64'(bus.rsp_instr.op_a), 64'd1);

        // Streaming at occupancy 1 across the pointer wrap.
        do_reset();
        pulse_start();
        drive(2'b01, PASSA, 99, 0, ZERO, 0, 0, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 40; k++) begin
            drive(2'b01, PASSA, 100 + k, 0, ZERO, 0, 0, 1'b1);
            #1;
            chk($sformatf("stream%0d_count", k), 64'(count), 64'd1);
            chk($sformatf("stream%0d_head", k), 64'(bus.rsp_instr.op_a), 64'(99 + k));
            chk($sformatf("stream%0d_rp", k), 64'(read_pointer), 64'(k % 32));
            chk($sformatf("stream%0d_wp", k), 64'(write_pointer), 64'((k + 1) % 32));
            @(negedge clk);
        end
        bus.req_valid = 2'b00;
        @(negedge clk);
        #1;
        chk("stream_empty", 64'(bus.rsp_valid), 64'd0);

        // Drain with 5 queued entries, back to IDLE, restart.
        do_reset();
        pulse_start();
        for (int j = 0; j < 5; j++) begin
            drive(2'b01, PASSA, j, 0, ZERO, 0, 0, 1'b0);
            @(negedge clk);
        end
        bus.req_valid = 2'b00;
        drain = 1'b1;
        @(negedge clk);
        drain = 1'b0;
        bus.req_valid = 2'b01;
        #1;
        chk("drain_ready", 64'(bus.req_ready), 64'd0);
        chk("drain_count", 64'(count), 64'd5);
        chk("drain_busy", 64'(busy), 64'd1);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            bus.rsp_ready = 1'b1;
            #1;
            chk($sformatf("drain_pop%0d_count", j), 64'(count), 64'(5 - j));
            chk($sformatf("drain_pop%0d_head", j), 64'(bus.rsp_instr.op_a), 64'(j));
            chk($sformatf("drain_pop%0d_ready", j), 64'(bus.req_ready), 64'd0);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        #1;
        chk("drained_count", 64'(count), 64'd0);
        chk("drained_busy", 64'(busy), 64'd1);
        @(negedge clk);
        #1;
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("restart_busy", 64'(busy), 64'd1);
        chk("restart_ready", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 2'b00;

        // Asynchronous reset in DRAIN with 7 entries held.
        do_reset();
        pulse_start();
        for (int j = 0; j < 9; j++) begin
            drive(2'b01, PASSA, j, 0, ZERO, 0, 0, 1'b0);
            @(negedge clk);
        end
        bus.req_valid = 2'b00;
        drain = 1'b1;
        @(negedge clk);
        drain = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        bus.rsp_ready = 1'b0;
        #1;
        chk("pre_rst_count", 64'(count), 64'd7);
        chk("pre_rst_rp", 64'(read_pointer), 64'd2);
        chk("pre_rst_wp", 64'(write_pointer), 64'd9);
        reset = 1'b1;
        #1;
        chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("async_rst_rsp_instr", bus.rsp_instr[63:0], 64'd0);
        chk("async_rst_wp", 64'(write_pointer), 64'd0);
        chk("async_rst_rp", 64'(read_pointer), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
